// File: rtl/chip_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : chip_shift_loader
// Purpose  : Serial back-end of the chip control path. Each accepted command
//            word is shifted MSB-first into the chip scan chain while the
//            chain's serial output is captured. The captured bits come back
//            as a parallel response word. The block also drives the divided
//            shift clock, the chain select and the latch strobe.
// Ports    : clk, rst                          - system clock, sync active-high reset
//            cmd_valid/cmd_ready/cmd_data      - command word in (valid/ready)
//            rsp_valid/rsp_ready/rsp_data      - captured word out (valid/ready)
//            rsp_perr                          - returned-parity mismatch flag
//            chip_sclk/chip_sdo/chip_sdi       - scan-chain shift clock and data
//            chip_cs_n/chip_latch              - chain select (low), load strobe
//            busy                              - high whenever not IDLE
// Options  : CHIP_SHIFT_PARITY_EN - appends one even-parity bit period to every
//            transfer and checks the parity bit returned by the chip.
// Revision : 1.0 - initial release
// ============================================================================
module chip_shift_loader #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_perr,
    output logic              chip_sclk,
    output logic              chip_sdo,
    input  logic              chip_sdi,
    output logic              chip_cs_n,
    output logic              chip_latch,
    output logic              busy
);

`ifdef CHIP_SHIFT_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int TOTAL_BITS = DATA_W + PAR_BITS;
    localparam int BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int PH_W       = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [PH_W-1:0]     phase_q;
    logic                sclk_q;
    logic                sdo_q;
    logic                cs_n_q;
    logic                latch_q;
    logic                busy_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic                w_phase_last;
    logic                w_sample;
    logic [BIT_W-1:0]    w_bit_cnt_inc;
    logic [DATA_W-1:0]   shreg_d;
    logic                sdo_d;

`ifdef CHIP_SHIFT_PARITY_EN
    logic                par_tx_q;
    logic                par_rx_q;
    logic                perr_q;
`endif

    // Ready is a pure decode so it is low while rst is held and high on the
    // very first cycle after rst is released.
    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign chip_sclk  = sclk_q;
    assign chip_sdo   = sdo_q;
    assign chip_cs_n  = cs_n_q;
    assign chip_latch = latch_q;
    assign busy       = busy_q;
`ifdef CHIP_SHIFT_PARITY_EN
    assign rsp_perr   = perr_q;
`else
    assign rsp_perr   = 1'b0;
`endif

    always_comb begin
        w_phase_last  = (phase_q == PH_W'(CLK_DIV - 1));
        w_bit_cnt_inc = bit_cnt_q + BIT_W'(1);
        // Data bits are captured on the first high cycle only; the parity bit
        // period (if any) never disturbs the captured word.
        w_sample      = (state_q == ST_SHIFT_HI) && (phase_q == '0) &&
                        (bit_cnt_q < BIT_W'(DATA_W));
        shreg_d       = w_sample ? {shreg_q[DATA_W-2:0], chip_sdi} : shreg_q;
        // Next bit to present is taken from the post-shift value so that a
        // one-cycle high phase (CLK_DIV=1) still advances correctly.
        sdo_d         = shreg_d[DATA_W-1];
`ifdef CHIP_SHIFT_PARITY_EN
        if (w_bit_cnt_inc == BIT_W'(DATA_W)) begin
            sdo_d = par_tx_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            phase_q     <= '0;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            latch_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef CHIP_SHIFT_PARITY_EN
            par_tx_q    <= 1'b0;
            par_rx_q    <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        shreg_q   <= cmd_data;
                        bit_cnt_q <= '0;
                        phase_q   <= '0;
                        sclk_q    <= 1'b0;
                        sdo_q     <= cmd_data[DATA_W-1];
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT_LO;
`ifdef CHIP_SHIFT_PARITY_EN
                        par_tx_q  <= ^cmd_data;
`endif
                    end
                end

                ST_SHIFT_LO: begin
                    if (w_phase_last) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= ST_SHIFT_HI;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end

                ST_SHIFT_HI: begin
                    shreg_q <= shreg_d;
`ifdef CHIP_SHIFT_PARITY_EN
                    if ((phase_q == '0) && (bit_cnt_q == BIT_W'(DATA_W))) begin
                        par_rx_q <= chip_sdi;
                    end
`endif
                    if (w_phase_last) begin
                        phase_q   <= '0;
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= w_bit_cnt_inc;
                        if (w_bit_cnt_inc < BIT_W'(TOTAL_BITS)) begin
                            sdo_q   <= sdo_d;
                            state_q <= ST_SHIFT_LO;
                        end else begin
                            sdo_q   <= 1'b0;
                            cs_n_q  <= 1'b1;
                            latch_q <= 1'b1;
                            state_q <= ST_LATCH;
                        end
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end

                ST_LATCH: begin
                    if (w_phase_last) begin
                        phase_q     <= '0;
                        latch_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= shreg_q;
`ifdef CHIP_SHIFT_PARITY_EN
                        perr_q      <= par_rx_q ^ (^shreg_q);
`endif
                        state_q     <= ST_RESP;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
`ifdef CHIP_SHIFT_PARITY_EN
                        perr_q      <= 1'b0;
`endif
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chip_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip_shift_loader
// Purpose  : Directed self-checking bench for chip_shift_loader. One instance
//            runs DATA_W=8/CLK_DIV=2 with a pattern-driven chip model, a second
//            runs DATA_W=8/CLK_DIV=1 with chip_sdi looped straight to chip_sdo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip_shift_loader;

`ifdef CHIP_SHIFT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_ready = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_perr;
    logic [7:0] rsp_data;
    logic       chip_sclk, chip_sdo, chip_sdi, chip_cs_n, chip_latch, busy;

    logic       cmd_valid1 = 1'b0;
    logic [7:0] cmd_data1 = 8'h00;
    logic       rsp_ready1 = 1'b0;
    logic       cmd_ready1, rsp_valid1, rsp_perr1;
    logic [7:0] rsp_data1;
    logic       chip_sclk1, chip_sdo1, chip_cs_n1, chip_latch1, busy1;

    int         vec = 0;
    int         miss = 0;

    always #5 clk = ~clk;

    chip_shift_loader #(.DATA_W(8), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_perr(rsp_perr),
        .chip_sclk(chip_sclk), .chip_sdo(chip_sdo), .chip_sdi(chip_sdi),
        .chip_cs_n(chip_cs_n), .chip_latch(chip_latch), .busy(busy)
    );

    chip_shift_loader #(.DATA_W(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_data(cmd_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_perr(rsp_perr1),
        .chip_sclk(chip_sclk1), .chip_sdo(chip_sdo1), .chip_sdi(chip_sdo1),
        .chip_cs_n(chip_cs_n1), .chip_latch(chip_latch1), .busy(busy1)
    );

    // Chip model: presents sdi_pat MSB-first, advancing one bit per falling
    // shift-clock edge while the chain is selected.
    logic [8:0] sdi_pat = 9'h000;
    int         k = 0;
    logic       prev_sclk = 1'b0;
    always @(posedge clk) begin
        prev_sclk <= chip_sclk;
        if (chip_cs_n) k <= 0;
        else if (prev_sclk && !chip_sclk) k <= k + 1;
    end
    assign chip_sdi = (k <= 8) ? sdi_pat[8-k] : 1'b0;

    int   lat;
    int   latch_cnt;
    int   csn_low;
    logic got;
    logic sdo_log [0:63];
    logic sclk_log[0:63];

    // Issues one command on dut and logs outputs until rsp_valid rises.
    task automatic run_cmd(input logic [7:0] data, input logic [8:0] pat);
        @(negedge clk);
        sdi_pat   = pat;
        cmd_valid = 1'b1;
        cmd_data  = data;
        vec++;
        if (cmd_ready !== 1'b1) begin
            miss++;
            $display("FAIL cmd_ready_before_cmd: got %b expected 1", cmd_ready);
        end
        @(posedge clk);
        lat = 0; latch_cnt = 0; csn_low = 0; got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            if (lat == 0) begin
                cmd_valid = 1'b0;
                cmd_data  = 8'h00;
            end
            lat++;
            if (lat <= 64) begin
                sdo_log[lat-1]  = chip_sdo;
                sclk_log[lat-1] = chip_sclk;
            end
            latch_cnt += int'(chip_latch);
            csn_low   += int'(!chip_cs_n);
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        vec++;
        if (!got) begin
            miss++;
            $display("FAIL rsp_timeout: got no rsp_valid within %0d cycles, expected by %0d", lat, 35 + 4*PB);
        end
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vec++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL %s_after_handshake: got ready=%b valid=%b busy=%b expected 1 0 0",
                     name, cmd_ready, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 ||
            rsp_perr !== 1'b0 || chip_sclk !== 1'b0 || chip_sdo !== 1'b0 ||
            chip_cs_n !== 1'b1 || chip_latch !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h pe=%b sclk=%b sdo=%b csn=%b lat=%b busy=%b expected 0 0 00 0 0 0 1 0 0",
                     cmd_ready, rsp_valid, rsp_data, rsp_perr, chip_sclk, chip_sdo, chip_cs_n, chip_latch, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (cmd_ready !== 1'b1 || cmd_ready1 !== 1'b1) begin
            miss++;
            $display("FAIL ready_after_reset: got %b/%b expected 1/1", cmd_ready, cmd_ready1);
        end
    endtask

    task automatic test_basic_shift();
        logic [7:0] c;
        c = 8'hA5;
        // chip_sdi is the previous bit of chip_sdo: 0 then A5[7:1]
        run_cmd(c, {8'h52, 1'b1});
        for (int i = 0; i < 32; i++) begin
            vec++;
            if (sdo_log[i] !== c[7 - i/4] || sclk_log[i] !== ((i % 4) >= 2)) begin
                miss++;
                $display("FAIL basic_bit_cycle%0d: got sdo=%b sclk=%b expected sdo=%b sclk=%b",
                         i + 1, sdo_log[i], sclk_log[i], c[7 - i/4], ((i % 4) >= 2));
            end
        end
        vec++;
        if (lat != 35 + 4*PB) begin
            miss++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, 35 + 4*PB);
        end
        vec++;
        if (rsp_data !== 8'h52 || busy !== 1'b1) begin
            miss++;
            $display("FAIL basic_rsp_data: got %h busy=%b expected 52 busy=1", rsp_data, busy);
        end
        finish_rsp("basic");
    endtask

    task automatic test_capture();
        run_cmd(8'hFF, {8'h3C, 1'b0});
        vec++;
        if (rsp_data !== 8'h3C) begin
            miss++;
            $display("FAIL capture_data: got %h expected 3c", rsp_data);
        end
        vec++;
        if (latch_cnt != 2) begin
            miss++;
            $display("FAIL capture_latch_width: got %0d expected 2", latch_cnt);
        end
        vec++;
        if (csn_low != 32 + 4*PB) begin
            miss++;
            $display("FAIL capture_csn_width: got %0d expected %0d", csn_low, 32 + 4*PB);
        end
        vec++;
        if (rsp_perr !== 1'b0) begin
            miss++;
            $display("FAIL capture_perr: got %b expected 0", rsp_perr);
        end
        finish_rsp("capture");
    endtask

    task automatic test_backpressure();
        run_cmd(8'h96, {8'h69, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h69 || cmd_ready !== 1'b0) begin
                miss++;
                $display("FAIL backpressure_hold%0d: got v=%b d=%h rdy=%b expected 1 69 0",
                         i, rsp_valid, rsp_data, cmd_ready);
            end
        end
        finish_rsp("backpressure");
    endtask

    task automatic test_reset_mid_shift();
        int bad_latch;
        int bad_valid;
        bad_latch = 0;
        bad_valid = 0;
        @(negedge clk);
        sdi_pat   = 9'h1FF;
        cmd_valid = 1'b1;
        cmd_data  = 8'hF0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (13) begin
            @(negedge clk);
            bad_latch += int'(chip_latch);
        end
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (chip_cs_n !== 1'b1 || chip_sclk !== 1'b0 || chip_latch !== 1'b0 ||
            rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL midreset_state: got csn=%b sclk=%b latch=%b v=%b busy=%b expected 1 0 0 0 0",
                     chip_cs_n, chip_sclk, chip_latch, rsp_valid, busy);
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            bad_latch += int'(chip_latch);
            bad_valid += int'(rsp_valid);
        end
        vec++;
        if (bad_latch != 0 || bad_valid != 0 || cmd_ready !== 1'b1) begin
            miss++;
            $display("FAIL midreset_no_latch: got latch=%0d valid=%0d rdy=%b expected 0 0 1",
                     bad_latch, bad_valid, cmd_ready);
        end
    endtask

    task automatic test_clkdiv1();
        int   n;
        logic ok;
        @(negedge clk);
        cmd_valid1 = 1'b1;
        cmd_data1  = 8'h01;
        @(posedge clk);
        n = 0; ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (n == 0) begin
                cmd_valid1 = 1'b0;
                cmd_data1  = 8'hFF;
            end
            n++;
            if (n <= 16) begin
                vec++;
                if (chip_sclk1 !== logic'((n - 1) % 2)) begin
                    miss++;
                    $display("FAIL div1_sclk_cycle%0d: got %b expected %0d", n, chip_sclk1, (n - 1) % 2);
                end
            end
            if (rsp_valid1 === 1'b1) ok = 1'b1;
        end
        vec++;
        if (!ok || n != 18 + 2*PB) begin
            miss++;
            $display("FAIL div1_latency: got %0d (valid=%b) expected %0d", n, ok, 18 + 2*PB);
        end
        vec++;
        if (rsp_data1 !== 8'h01 || rsp_perr1 !== 1'b0) begin
            miss++;
            $display("FAIL div1_rsp: got %h perr=%b expected 01 perr=0", rsp_data1, rsp_perr1);
        end
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        vec++;
        if (cmd_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
            miss++;
            $display("FAIL div1_handshake: got rdy=%b v=%b expected 1 0", cmd_ready1, rsp_valid1);
        end
    endtask

    task automatic test_parity();
        // Chip returns 0x00 followed by a 1 in the parity slot.
        run_cmd(8'h07, {8'h00, 1'b1});
`ifdef CHIP_SHIFT_PARITY_EN
        for (int i = 32; i < 36; i++) begin
            vec++;
            if (sdo_log[i] !== 1'b1) begin
                miss++;
                $display("FAIL parity_bit_out_cycle%0d: got %b expected 1", i + 1, sdo_log[i]);
            end
        end
`endif
        vec++;
        if (lat != 35 + 4*PB) begin
            miss++;
            $display("FAIL parity_latency: got %0d expected %0d", lat, 35 + 4*PB);
        end
        vec++;
        if (rsp_perr !== logic'(PB) || rsp_data !== 8'h00) begin
            miss++;
            $display("FAIL parity_flag: got perr=%b data=%h expected perr=%0d data=00", rsp_perr, rsp_data, PB);
        end
        finish_rsp("parity");
    endtask

    initial begin
        test_reset();
        test_basic_shift();
        test_capture();
        test_backpressure();
        test_reset_mid_shift();
        test_clkdiv1();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chip_shift_loader.md
Name: chip_shift_loader

Overview:
- Serial back-end of the chip control path: consumes parallel command words from the chip controller and shifts them MSB-first into the Bayesian machine's configuration/memory scan chain.
- Simultaneously captures the chain's serial output and returns it as a parallel response word.
- Generates the chain's divided shift clock, chip select and latch strobe. Sits between the chip controller (upstream) and the chip pads (downstream).

Parameters:
- DATA_W, 32, bits per command word and per response word; must be ≥2.
- CLK_DIV, 4, system cycles per shift-clock half period; must be ≥1.

Ports:
- clk  in  1  system clock (seq clock)
- rst  in  1  synchronous active-high reset (seq reset)
- cmd_valid  in  1  command word available
- cmd_ready  out  1  block can accept a command
- cmd_data  in  DATA_W  word to shift into chain
- rsp_valid  out  1  response word available
- rsp_ready  in  1  upstream accepts response
- rsp_data  out  DATA_W  bits captured from chain
- rsp_perr  out  1  parity error flag (see Optional Feature)
- chip_sclk  out  1  shift clock to chip
- chip_sdo  out  1  serial data to chip
- chip_sdi  in  1  serial data from chip
- chip_cs_n  out  1  chain select, active low
- chip_latch  out  1  parallel-load strobe to chip
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: cmd_ready=0 during rst, 1 on the first cycle after it. All other outputs reset to 0, except chip_cs_n=1. Reset is honoured in any state and aborts a shift in progress without a latch pulse.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, RESP.
- IDLE: cmd_ready=1 only in IDLE. A handshake at cycle T (cmd_valid && cmd_ready):
  - loads the shift register with cmd_data;
  - clears the bit counter and phase counter;
  - goes to SHIFT_LO at T+1;
  - chip_cs_n falls at T+1.
- SHIFT_LO:
  - chip_sclk=0 and chip_sdo = current MSB of the shift register.
  - Lasts CLK_DIV cycles, then goes to SHIFT_HI.
- SHIFT_HI:
  - chip_sclk=1 for CLK_DIV cycles.
  - On the first SHIFT_HI cycle, chip_sdi is sampled into the LSB and the register shifts left by one.
  - At the end of SHIFT_HI, bit counter increments; go to SHIFT_LO if count < DATA_W, else LATCH.
- LATCH:
  - chip_latch=1, chip_cs_n=1, chip_sclk=0 for CLK_DIV cycles.
  - Then go to RESP; the register holds the captured word.
- RESP:
  - rsp_valid=1 and rsp_data = captured word, held stable until rsp_ready.
  - Handshake → IDLE on the next cycle.
  - rsp_ready while rsp_valid=0 is ignored.
- Latency: rsp_valid first rises at T+1+2·CLK_DIV·DATA_W+CLK_DIV.
- Back-to-back: the next command can be accepted no earlier than the cycle after the response handshake. There is no overlap of shifting and response.
- chip_sdo and chip_cs_n change only at the start of SHIFT_LO or at LATCH entry. chip_sdo is never mid-phase glitch-free-violated.
- Counters: bit counter width clog2(DATA_W+1); phase counter width clog2(CLK_DIV+1). Neither wraps inside a transaction.
- cmd_data changes while not handshaking have no effect.

Optional Feature:
- Macro: CHIP_SHIFT_PARITY_EN.
- Enabled:
  - After DATA_W data bits, one extra bit period shifts out the even parity of cmd_data.
  - The chip's returned extra bit is compared with the even parity of the captured DATA_W bits; rsp_perr=1 on mismatch, valid with rsp_valid.
  - Latency grows by 2·CLK_DIV.
- Disabled: no extra bit; rsp_perr tied 0.

Test Plan:
- Basic shift (DATA_W=8, CLK_DIV=2): cmd 0xA5, chip_sdi looped from chip_sdo delayed one bit → chip_sdo sequence 1,0,1,0,0,1,0,1. Each bit held 4 cycles. rsp_valid at T+35.
- Capture: chip_sdi forced to pattern 0x3C MSB-first, cmd 0xFF → rsp_data=0x3C, chip_latch high exactly 2 cycles, chip_cs_n low exactly 32 cycles.
- Backpressure: rsp_ready held 0 for 10 cycles → rsp_valid/rsp_data stable, cmd_ready=0 throughout. Handshake → cmd_ready=1 next cycle.
- Reset mid-shift: rst asserted after bit 3 → next cycle chip_cs_n=1, chip_sclk=0, chip_latch=0, rsp_valid=0, busy=0. No latch pulse ever emitted.
- CLK_DIV=1 boundary: cmd 0x01, DATA_W=8 → sclk toggles every cycle, rsp_valid at T+18.
- Parity (macro on, DATA_W=8, CLK_DIV=2): cmd 0x07 → 9th bit out =1. Chip returns 0x00 with parity bit 1 → rsp_perr=1, rsp_valid at T+39.
